// File: rtl/enoc_switch_allocator.sv
// Wormhole switch allocator: per-output round-robin arbitration, output held by its owner until the tail flit.
// Zero-cycle grant latency; a low i_en[o] or an absent owner request withholds the grant without losing the lock.
module enoc_switch_allocator #(
  parameter int PORTS = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [0:PORTS-1][0:PORTS-1]    i_output_req,
  input  logic [0:PORTS-1]               i_tail,
  input  logic [0:PORTS-1]               i_en,
  output logic [0:PORTS-1][0:PORTS-1]    o_output_grant,
  output logic [0:PORTS-1][0:PORTS-1]    o_input_sel
);

  localparam int IW = $clog2(PORTS);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                        r_state     [PORTS];
  logic   [IW-1:0]               r_owner     [PORTS];
  logic   [IW-1:0]               r_ptr       [PORTS];
  state_t                        w_state_nxt [PORTS];
  logic   [IW-1:0]               w_owner_nxt [PORTS];
  logic   [IW-1:0]               w_ptr_nxt   [PORTS];
  logic   [IW-1:0]               w_win       [PORTS];
  logic                          w_found     [PORTS];
  logic   [0:PORTS-1][0:PORTS-1] w_sel;
  int                            w_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < PORTS; o++) begin
        r_state[o] <= S_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_ptr[o]   <= w_ptr_nxt[o];
      end
    end
  end

  always_comb begin
    w_sel = '0;
    w_idx = 0;
    for (int o = 0; o < PORTS; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_ptr_nxt[o]   = r_ptr[o];
      w_win[o]       = '0;
      w_found[o]     = 1'b0;
    end
    for (int o = 0; o < PORTS; o++) begin
      if (r_state[o] == S_LOCKED) begin
        if (i_output_req[r_owner[o]][o] && i_en[o]) begin
          w_sel[o][r_owner[o]] = 1'b1;
          if (i_tail[r_owner[o]]) w_state_nxt[o] = S_IDLE;
        end
      end else if (i_en[o]) begin
        // Search upward from the pointer, wrapping, so the last winner goes to the back of the line.
        for (int k = 0; k < PORTS; k++) begin
          w_idx = int'(r_ptr[o]) + k;
          if (w_idx >= PORTS) w_idx = w_idx - PORTS;
          if (!w_found[o] && i_output_req[w_idx][o]) begin
            w_found[o] = 1'b1;
            w_win[o]   = IW'(w_idx);
          end
        end
        if (w_found[o]) begin
          w_sel[o][w_win[o]] = 1'b1;
          w_ptr_nxt[o] = (w_win[o] == IW'(PORTS - 1)) ? '0 : w_win[o] + IW'(1);
          if (!i_tail[w_win[o]]) begin
            w_state_nxt[o] = S_LOCKED;
            w_owner_nxt[o] = w_win[o];
          end
        end
      end
    end
    if (reset) w_sel = '0;
  end

  always_comb begin
    o_input_sel    = w_sel;
    o_output_grant = '0;
    for (int i = 0; i < PORTS; i++) begin
      for (int o = 0; o < PORTS; o++) begin
        o_output_grant[i][o] = w_sel[o][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PORTS; i++) begin
        assert ($onehot0(i_output_req[i]));
      end
    end
  end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Bench for enoc_switch_allocator: directed packet scenarios with literal expectations, then random traffic vs. a reference model.
module tb_enoc_switch_allocator;

  localparam int P = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [0:P-1][0:P-1] req;
  logic [0:P-1]        tail;
  logic [0:P-1]        en;
  logic [0:P-1][0:P-1] grant;
  logic [0:P-1][0:P-1] sel;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: owner = -1 means the output is free.
  int m_owner [P] = '{-1, -1, -1, -1, -1};
  int m_ptr   [P] = '{0, 0, 0, 0, 0};
  int n_owner [P] = '{-1, -1, -1, -1, -1};
  int n_ptr   [P] = '{0, 0, 0, 0, 0};
  logic [0:P-1][0:P-1] exp_grant;
  logic [0:P-1][0:P-1] exp_sel;

  enoc_switch_allocator #(.PORTS(P)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_output_req   (req),
    .i_tail         (tail),
    .i_en           (en),
    .o_output_grant (grant),
    .o_input_sel    (sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  // Reference model evaluated mid-cycle, committed on the rising edge.
  always @(negedge clk) begin
    int w;
    int c;
    exp_grant = '0;
    exp_sel   = '0;
    for (int o = 0; o < P; o++) begin
      n_owner[o] = m_owner[o];
      n_ptr[o]   = m_ptr[o];
    end
    if (reset) begin
      for (int o = 0; o < P; o++) begin
        n_owner[o] = -1;
        n_ptr[o]   = 0;
      end
    end else begin
      for (int o = 0; o < P; o++) begin
        w = -1;
        if (m_owner[o] >= 0) begin
          if (req[m_owner[o]][o] && en[o]) w = m_owner[o];
        end else if (en[o]) begin
          for (int k = 0; k < P; k++) begin
            c = (m_ptr[o] + k) % P;
            if (w < 0 && req[c][o]) w = c;
          end
        end
        if (w >= 0) begin
          exp_grant[w][o] = 1'b1;
          exp_sel[o][w]   = 1'b1;
          if (m_owner[o] < 0) n_ptr[o] = (w + 1) % P;
          n_owner[o] = tail[w] ? -1 : w;
        end
      end
    end
    chk("model_grant", 32'(grant), 32'(exp_grant));
    chk("model_sel",   32'(sel),   32'(exp_sel));
  end

  always @(posedge clk) begin
    for (int o = 0; o < P; o++) begin
      m_owner[o] = n_owner[o];
      m_ptr[o]   = n_ptr[o];
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    req  = '0;
    tail = '0;
    en   = '1;
  endtask

  logic [0:P-1] oh;
  logic [0:P-1] rr_exp [4] = '{5'b10000, 5'b00010, 5'b00001, 5'b10000};

  initial begin
    reset = 1'b1;
    clr();
    #1;
    mid();
    chk("reset_grant", 32'(grant), 32'd0);
    nxt();
    req[1] = 5'b00100;
    tail[1] = 1'b1;
    mid();
    chk("reset_req_ignored", 32'(grant), 32'd0);
    nxt();
    reset = 1'b0;
    clr();
    mid();
    chk("idle_no_grant", 32'(grant), 32'd0);

    // Single flit n -> e
    nxt();
    req[1] = 5'b00100;
    tail[1] = 1'b1;
    mid();
    chk("single_grant_n", 32'(grant[1]), 32'(5'b00100));
    chk("single_sel_e",   32'(sel[2]),   32'(5'b01000));
    nxt();
    clr();
    chk("model_ptr_e",   32'(m_ptr[2]),   32'd2);
    chk("model_owner_e", 32'(m_owner[2]), 32'hFFFF_FFFF);

    // Round robin on output n among inputs 0, 3, 4
    req[0] = 5'b01000; req[3] = 5'b01000; req[4] = 5'b01000;
    tail = '1;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk("rr_winner", 32'(sel[1]), 32'(rr_exp[c]));
      nxt();
    end
    clr();

    // Wormhole lock on w: first move ptr[w] past input 1
    req[1] = 5'b00001; tail[1] = 1'b1;
    mid();
    chk("worm_prelim", 32'(sel[4]), 32'(5'b01000));
    nxt();
    req[2] = 5'b00001; tail[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) tail[2] = 1'b1;
      mid();
      chk("worm_owner", 32'(sel[4]), 32'(5'b00100));
      nxt();
    end
    req[2] = '0; tail[2] = 1'b0;
    mid();
    chk("worm_next", 32'(sel[4]), 32'(5'b01000));
    nxt();
    clr();

    // Back-pressure mid-packet on output c
    req[3] = 5'b10000; req[4] = 5'b10000; tail[4] = 1'b1;
    mid();
    chk("bp_head", 32'(sel[0]), 32'(5'b00010));
    nxt();
    en[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mid();
      chk("bp_stall_sel", 32'(sel[0]),   32'd0);
      chk("bp_stall_in4", 32'(grant[4]), 32'd0);
      nxt();
    end
    en[0] = 1'b1;
    mid();
    chk("bp_resume", 32'(sel[0]), 32'(5'b00010));
    nxt();
    tail[3] = 1'b1;
    mid();
    chk("bp_tail", 32'(sel[0]), 32'(5'b00010));
    nxt();
    req[3] = '0;
    mid();
    chk("bp_other", 32'(sel[0]), 32'(5'b00001));
    nxt();
    clr();

    // Five disjoint transfers at once
    req[0] = 5'b01000; req[1] = 5'b00010; req[2] = 5'b00001;
    req[3] = 5'b10000; req[4] = 5'b00100;
    tail = '1;
    mid();
    chk("par_g0", 32'(grant[0]), 32'(5'b01000));
    chk("par_g1", 32'(grant[1]), 32'(5'b00010));
    chk("par_g2", 32'(grant[2]), 32'(5'b00001));
    chk("par_g3", 32'(grant[3]), 32'(5'b10000));
    chk("par_g4", 32'(grant[4]), 32'(5'b00100));
    nxt();
    clr();

    // Reset drops a lock held by input 4 on e
    req[4] = 5'b00100;
    mid();
    chk("rst_lock", 32'(sel[2]), 32'(5'b00001));
    nxt();
    reset = 1'b1;
    mid();
    chk("rst_zero", 32'(grant), 32'd0);
    nxt();
    reset = 1'b0;
    req[1] = 5'b00100; tail[1] = 1'b1;
    mid();
    chk("rst_new_winner", 32'(sel[2]), 32'(5'b01000));
    nxt();
    clr();

    // Random traffic, checked every cycle by the model process
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < P; i++) begin
        oh = 5'b10000;
        oh = oh >> $urandom_range(0, P - 1);
        req[i]  = ($urandom_range(0, 9) < 6) ? oh : '0;
        tail[i] = ($urandom_range(0, 2) == 0);
        en[i]   = ($urandom_range(0, 4) != 0);
      end
      reset = ($urandom_range(0, 99) == 0);
      nxt();
    end
    reset = 1'b0;
    clr();
    mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
